modpoly_reduce: RTL and testbench
=================================

# modpoly_reduce

Reduces a raw polynomial product held in a 13-bit coefficient RAM from 2P-1 = 1521 coefficients to P = 761 coefficients modulo x^P - x - 1, with every coefficient also reduced modulo Q = 4591. It sits directly downstream of the product RAM: it drives that RAM's asynchronous read port, receives the read data, and writes the reduced polynomial through a RAM-style write port into the next stage's memory. A start/busy/done handshake sequences one reduction per start.

## Interface
- P, 761: output polynomial length; input length is 2P-1.
- Q, 4591: coefficient modulus.
- COEF_W, 13: coefficient width.
- ADDR_W, 11: RAM address width.

- clk  in  1  rising-edge clock, the single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a reduction; sampled only in IDLE.
- busy  out  1  high while a reduction is in progress.
- done  out  1  one-cycle pulse after the last coefficient write.
- read_address  out  ADDR_W  address to the product RAM, which has a combinational read.
- read_data  in  COEF_W  product RAM data for read_address, valid in the same cycle.
- write_enable  out  1  registered write strobe to the result RAM.
- write_address  out  ADDR_W  registered result index, 0..P-1.
- write_data  out  COEF_W  registered reduced coefficient in [0,Q-1].

## Operation
- Math: x^P = x + 1, so r[i] = c[i] + c[P+i] (only for i ≤ P-2) + c[P+i-1] (only for i ≥ 1). Missing terms are 0.
- Input coefficients are in [0,Q-1]. Output for out-of-range inputs is unspecified.
- State machine: IDLE, LO, HI, FIN. Registers: index i (ADDR_W bits), lo (COEF_W), hi_prev (COEF_W).
- IDLE: read_address = 0. If start is high, then i <= 0, hi_prev <= 0, and the next state is LO.
- LO: read_address = i; lo <= read_data; next state is HI.
- HI:
  - read_address = P+i when i ≤ P-2. Otherwise read_address = 0 and hi is forced to 0.
  - Compute s = lo + hi + hi_prev, 15 bits unsigned, maximum 3(Q-1) = 13770.
  - If s ≥ 2Q, subtract 2Q. Else if s ≥ Q, subtract Q.
  - Register write_enable <= 1, write_address <= i, write_data <= reduced s; hi_prev <= hi.
  - If i = P-1, the next state is FIN. Otherwise i <= i+1 and the next state is LO.
- FIN: one cycle. Register done <= 1 for the following cycle; next state is IDLE.
- write_enable is deasserted in every cycle that does not follow a HI cycle.
- Writes occur in strictly ascending address order, exactly P writes per run.
- The product RAM is never read at address ≥ 2P-1.
- start is ignored while busy (LO, HI, FIN). start in the cycle where done is high is accepted, because the state is already IDLE.
- Reset, including mid-run: asynchronous return to IDLE. All outputs go to 0 immediately and no further writes occur. Partial result RAM contents are left as written and are don't-care.

## Timing
- Reset values: busy = 0, done = 0, write_enable = 0, write_address = 0, write_data = 0, read_address = 0. Internal registers i, lo and hi_prev are 0.
- Cycle numbering: start is sampled high at the edge ending cycle 0.
- busy is high in cycles 1..2P+1 (1..1523).
- The write for coefficient i is presented in cycle 2i+3: first at cycle 3, last (i = 760) at cycle 1523.
- done is high in cycle 2P+2 (1524), and busy is low in that cycle.
- Latency from start to done is 2P+2 cycles. Throughput is one coefficient per 2 cycles.
- read_address is combinational from state and i. read_data is sampled at the same edge.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 without waiting for a clock edge. After release, outputs hold at 0 until start.
- Single x^761 term: c[761] = 1, all others 0 -> r[0] = 1, r[1] = 1, all other r = 0. Exactly 761 writes, done in cycle 1524.
- Top term: c[1520] = 1, all others 0 -> r[759] = 1, r[760] = 1, all others 0. read_address never exceeds 1520.
- Modular wrap: c[5] = c[765] = c[766] = 4590 -> r[5] = 4588, r[4] = 4590, r[6] = 4590, all others 0.
- Random product (coefficients uniform in [0,4590]) versus a golden model -> all 761 outputs match. Write addresses are 0..760 at cycles 3, 5, ..., 1523.
- Control:
  - A start pulse at cycle 100 during a run -> ignored; the trace is unchanged.
  - rst at cycle 500 -> no writes after reset.
  - A new start after reset -> a full, correct run with done at 1524 cycles after that start.
  - Back-to-back: start in the done cycle -> a second run begins in the next cycle.

Source files
------------

// File: rtl/modpoly_reduce_if.sv
// Bus bundle for modpoly_reduce: start/busy/done handshake, the product RAM
// read port, and the result RAM write port.
interface modpoly_reduce_if #(
    parameter int COEF_W = 13,
    parameter int ADDR_W = 11
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] read_address;
    logic [COEF_W-1:0] read_data;
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;
    logic [COEF_W-1:0] write_data;

    modport master (
        output start,
        input  busy,
        input  done,
        input  read_address,
        output read_data,
        input  write_enable,
        input  write_address,
        input  write_data
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output read_address,
        input  read_data,
        output write_enable,
        output write_address,
        output write_data
    );
endinterface

// File: rtl/modpoly_reduce.sv
// Reduces a 2P-1 coefficient product modulo x^P - x - 1 and each coefficient
// modulo Q, streaming one reduced coefficient out every two cycles.
module modpoly_reduce #(
    parameter int P      = 761,
    parameter int Q      = 4591,
    parameter int COEF_W = 13,
    parameter int ADDR_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    modpoly_reduce_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(P - 1);
    localparam logic [ADDR_W-1:0] PEN_IDX  = ADDR_W'(P - 2);
    localparam logic [ADDR_W-1:0] HI_BASE  = ADDR_W'(P);
    localparam logic [14:0]       Q1       = 15'(Q);
    localparam logic [14:0]       Q2       = 15'(2 * Q);

    // Sum of three values in [0,Q-1] lies below 3Q, so two conditional subtracts suffice.
    function automatic logic [COEF_W-1:0] mod_q3(input logic [14:0] s);
        logic [14:0] t;
        if (s >= Q2) begin
            t = s - Q2;
        end else if (s >= Q1) begin
            t = s - Q1;
        end else begin
            t = s;
        end
        return COEF_W'(t);
    endfunction

    state_t            state_q;
    logic [ADDR_W-1:0] i_q;
    logic [COEF_W-1:0] lo_q;
    logic [COEF_W-1:0] hi_prev_q;
    logic              busy_q;
    logic              done_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [COEF_W-1:0] wdata_q;

    logic [ADDR_W-1:0] raddr_s;
    logic [COEF_W-1:0] hi_s;
    logic [14:0]       sum_s;
    logic [COEF_W-1:0] red_s;

    // Product RAM address and high-half term; c[P+i] does not exist for i = P-1.
    always_comb begin
        raddr_s = '0;
        hi_s    = '0;
        case (state_q)
            LO: begin
                raddr_s = i_q;
            end
            HI: begin
                if (i_q <= PEN_IDX) begin
                    raddr_s = HI_BASE + i_q;
                    hi_s    = bus.read_data;
                end else begin
                    raddr_s = '0;
                    hi_s    = '0;
                end
            end
            default: begin
                raddr_s = '0;
            end
        endcase
    end

    assign sum_s = 15'(lo_q) + 15'(hi_s) + 15'(hi_prev_q);
    assign red_s = mod_q3(sum_s);

    // Sequencer: LO fetches c[i], HI fetches c[P+i] and emits r[i].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            lo_q      <= '0;
            hi_prev_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        i_q       <= '0;
                        hi_prev_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= LO;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                LO: begin
                    lo_q    <= bus.read_data;
                    state_q <= HI;
                end
                HI: begin
                    we_q      <= 1'b1;
                    waddr_q   <= i_q;
                    wdata_q   <= red_s;
                    hi_prev_q <= hi_s;
                    if (i_q == LAST_IDX) begin
                        state_q <= FIN;
                    end else begin
                        i_q     <= i_q + ADDR_W'(1);
                        state_q <= LO;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.read_address  = raddr_s;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.write_enable  = we_q;
    assign bus.write_address = waddr_q;
    assign bus.write_data    = wdata_q;
endmodule

// File: tb/tb_modpoly_reduce.sv
// Directed and random checks of modpoly_reduce against hand-computed vectors
// and an independent modulo-based golden model.
module tb_modpoly_reduce;
    localparam int P = 761;
    localparam int Q = 4591;
    localparam int N = 2 * P - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    modpoly_reduce_if #(.COEF_W(13), .ADDR_W(11)) bus ();

    modpoly_reduce #(.P(P), .Q(Q), .COEF_W(13), .ADDR_W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [12:0] prod [0:N-1];
    assign bus.read_data = (bus.read_address < 11'd1521) ? prod[bus.read_address] : 13'd0;

    typedef struct {
        int a0; int v0; int a1; int v1; int a2; int v2;
        int ea0; int ev0; int ea1; int ev1; int ea2; int ev2;
    } vec_t;

    vec_t vecs [4];
    int   res   [0:P-1];
    int   exp_r [0:P-1];

    int cyc = 0;
    int start_cyc = 0;
    int wr_cnt = 0;
    int seq_err = 0;
    int rd_err = 0;
    int post_rst = 0;
    int post_rst_wr = 0;
    int done_rel, busy1, busy_done;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/read monitor sampled on the falling edge
    always @(negedge clk) begin
        if (bus.read_address > 11'd1520) rd_err++;
        if (bus.write_enable) begin
            if (int'(bus.write_address) != wr_cnt || (cyc - start_cyc) != 2 * wr_cnt + 3)
                seq_err++;
            if (bus.write_address < 11'd761) res[bus.write_address] = int'(bus.write_data);
            wr_cnt++;
            if (post_rst != 0) post_rst_wr++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_term(input int a, input int v);
        if (a >= 0) prod[a] = 13'(v);
    endtask

    task automatic set_exp(input int a, input int v);
        if (a >= 0) exp_r[a] = v;
    endtask

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < N; k++) prod[k] = 13'd0;
        for (int k = 0; k < P; k++) exp_r[k] = 0;
        set_term(v.a0, v.v0); set_term(v.a1, v.v1); set_term(v.a2, v.v2);
        set_exp(v.ea0, v.ev0); set_exp(v.ea1, v.ev1); set_exp(v.ea2, v.ev2);
    endtask

    task automatic golden();
        for (int k = 0; k < P; k++) begin
            int s;
            s = int'(prod[k]);
            if (k <= P - 2) s += int'(prod[P + k]);
            if (k >= 1)     s += int'(prod[P + k - 1]);
            exp_r[k] = s % Q;
        end
    endtask

    // Starts a run at the current falling edge; optional mid-run start poke or reset.
    task automatic run(input int poke, input int rst_at, input bit chain);
        int rel;
        for (int k = 0; k < P; k++) res[k] = -1;
        start_cyc = cyc; wr_cnt = 0; seq_err = 0; rd_err = 0; post_rst_wr = 0;
        done_rel = -1; busy1 = -1; busy_done = -1;
        bus.start = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            rel = cyc - start_cyc;
            bus.start = (rel == poke) ? 1'b1 : 1'b0;
            if (rel == 1) busy1 = int'(bus.busy);
            if (rel == rst_at) begin
                #2 rst = 1'b1;
                post_rst = 1;
                #1;
                chk("rst_async_outs", int'(|{bus.busy, bus.done, bus.write_enable,
                    bus.write_address, bus.write_data, bus.read_address}), 0);
                bus.start = 1'b0;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                repeat (20) @(negedge clk);
                chk("rst_no_writes", post_rst_wr, 0);
                chk("rst_idle_busy", int'(bus.busy), 0);
                chk("rst_idle_outs", int'(|{bus.done, bus.write_enable, bus.write_address,
                    bus.write_data, bus.read_address}), 0);
                post_rst = 0;
                return;
            end
            if (bus.done) begin
                done_rel  = rel;
                busy_done = int'(bus.busy);
                if (chain) bus.start = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_run(input string name);
        int mism;
        mism = 0;
        for (int k = 0; k < P; k++) if (res[k] != exp_r[k]) mism++;
        chk({name, "_done_cycle"}, done_rel, 2 * P + 2);
        chk({name, "_busy_c1"}, busy1, 1);
        chk({name, "_busy_at_done"}, busy_done, 0);
        chk({name, "_writes"}, wr_cnt, P);
        chk({name, "_write_order"}, seq_err, 0);
        chk({name, "_read_range"}, rd_err, 0);
        chk({name, "_data_mismatches"}, mism, 0);
    endtask

    initial begin
        vecs[0] = '{761, 1, -1, 0, -1, 0, 0, 1, 1, 1, -1, 0};
        vecs[1] = '{1520, 1, -1, 0, -1, 0, 759, 1, 760, 1, -1, 0};
        vecs[2] = '{5, 4590, 765, 4590, 766, 4590, 5, 4588, 4, 4590, 6, 4590};
        vecs[3] = '{0, 4590, 760, 7, 1520, 4590, 0, 4590, 759, 4590, 760, 6};

        rst = 1'b1;
        bus.start = 1'b0;
        for (int k = 0; k < N; k++) prod[k] = 13'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_we", int'(bus.write_enable), 0);
        chk("reset_waddr", int'(bus.write_address), 0);
        chk("reset_wdata", int'(bus.write_data), 0);
        chk("reset_raddr", int'(bus.read_address), 0);

        for (int v = 0; v < 4; v++) begin
            load_vec(vecs[v]);
            run(-1, -1, 1'b0);
            check_run($sformatf("vec%0d", v));
        end

        for (int k = 0; k < N; k++) prod[k] = 13'($urandom_range(0, Q - 1));
        golden();
        run(100, -1, 1'b0);
        check_run("rand_poke100");

        run(-1, 500, 1'b0);
        run(-1, -1, 1'b0);
        check_run("after_rst");

        load_vec(vecs[0]);
        run(-1, -1, 1'b1);
        check_run("b2b_first");
        run(-1, -1, 1'b0);
        check_run("b2b_second");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
